// File: rtl/axis_stream_comparator_pkg.sv
// Shared definitions for the AXIS stream comparator.
// Contents:
//   state_e    - checker state machine encoding (IDLE, RUN, DONE, FAIL)
//   CNT_WIDTH  - width of every result counter
//   LANE_MAX   - widest lane the lane comparator helper accepts
//   lane_match - tolerance compare of one lane (dut vs reference)
//   sat_inc    - saturating counter increment
package axis_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam int CNT_WIDTH = 32;
  localparam int LANE_MAX  = 64;

  // Lanes arrive zero-extended to LANE_MAX bits, so the unsigned absolute
  // difference here equals the one taken on LANE_WIDTH+1 bits. Any unknown
  // bit in the observed lane forces a failure.
  function automatic logic lane_match(input logic [LANE_MAX-1:0] dut,
                                      input logic [LANE_MAX-1:0] ref_lane,
                                      input logic [LANE_MAX-1:0] tol);
    logic [LANE_MAX-1:0] diff;
    if (dut >= ref_lane) begin
      diff = dut - ref_lane;
    end else begin
      diff = ref_lane - dut;
    end
    return (diff <= tol) && !$isunknown(dut);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/axis_stream_comparator_ref_fifo.sv
// checker_ref_fifo: first-word-fall-through synchronous FIFO holding the
// reference stream. dout always shows the head entry when not empty.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset (empties the FIFO)
//   push  in   write din (ignored when full)
//   pop   in   drop head entry (ignored when empty)
//   din   in   WIDTH write data
//   dout  out  WIDTH head entry
//   full  out  DEPTH entries held
//   empty out  no entries held
module checker_ref_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate reads
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/axis_stream_comparator.sv
// axis_stream_comparator: passive checker that watches a DUT AXIS handshake,
// buffers an independent reference stream and compares each observed beat
// lane-by-lane with a tolerance.
// Ports:
//   clk, rst (async active-low)
//   dut_valid/dut_ready/dut_data  observed handshake (never driven)
//   ref_valid/ref_data/ref_ready  reference stream into the internal FIFO
//   beat_count, mismatch_count, underrun_count  saturating result counters
//   first_err_index, first_err_mask             capture of the first failure
//   err (sticky failure), timeout (sticky watchdog), done (DONE state)
module axis_stream_comparator
  import axis_checker_pkg::*;
#(
  parameter int LANE_WIDTH     = 16,
  parameter int NUM_LANES      = 4,
  parameter int TOLERANCE      = 0,
  parameter int REF_DEPTH      = 16,
  parameter int EXPECTED_BEATS = 1024,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STOP_ON_ERROR  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dut_valid,
  input  logic                            dut_ready,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] dut_data,
  input  logic                            ref_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] ref_data,
  output logic                            ref_ready,
  output logic [31:0]                     beat_count,
  output logic [31:0]                     mismatch_count,
  output logic [31:0]                     underrun_count,
  output logic [31:0]                     first_err_index,
  output logic [NUM_LANES-1:0]            first_err_mask,
  output logic                            err,
  output logic                            timeout,
  output logic                            done
);

  localparam int DW = NUM_LANES * LANE_WIDTH;

  state_e                 state_r;
  state_e                 state_next_s;
  logic                   beat_s;
  logic                   take_s;
  logic                   fifo_push_s;
  logic                   fifo_pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   bypass_s;
  logic                   underrun_s;
  logic                   mismatch_s;
  logic                   failure_s;
  logic                   wd_hit_s;
  logic [DW-1:0]          fifo_dout_s;
  logic [DW-1:0]          cmp_ref_s;
  logic [NUM_LANES-1:0]   fail_mask_s;
  logic [CNT_WIDTH-1:0]   cnt_next_s;
  logic [CNT_WIDTH-1:0]   wd_r;
  logic                   first_err_valid_r;

  checker_ref_fifo #(
    .WIDTH (DW),
    .DEPTH (REF_DEPTH)
  ) u_ref_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (ref_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Depends only on FIFO state, never on dut_*.
  assign ref_ready = !fifo_full_s;

  // Beat classification, bypass mux and lane comparators
  always_comb begin
    beat_s     = dut_valid & dut_ready;
    take_s     = beat_s & ((state_r == IDLE) || (state_r == RUN));
    fifo_pop_s = take_s & !fifo_empty_s;
    bypass_s   = take_s & fifo_empty_s & ref_valid;
    underrun_s = take_s & fifo_empty_s & !ref_valid;
    // A bypassed reference beat is consumed directly and never stored.
    fifo_push_s = ref_valid & !fifo_full_s & !bypass_s;
    cmp_ref_s   = fifo_empty_s ? ref_data : fifo_dout_s;
    fail_mask_s = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      fail_mask_s[i] = !lane_match(LANE_MAX'(dut_data[i*LANE_WIDTH +: LANE_WIDTH]),
                                   LANE_MAX'(cmp_ref_s[i*LANE_WIDTH +: LANE_WIDTH]),
                                   LANE_MAX'(TOLERANCE));
    end
    mismatch_s = (fifo_pop_s | bypass_s) & (|fail_mask_s);
    failure_s  = mismatch_s | underrun_s;
    cnt_next_s = sat_inc(beat_count);
    // Fires on the idle cycle that brings the watchdog up to its limit.
    wd_hit_s   = (TIMEOUT_CYCLES != 0) && (state_r == RUN) && !beat_s &&
                 ((wd_r + 32'd1) == CNT_WIDTH'(TIMEOUT_CYCLES));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a stopping failure wins over completion
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, RUN: begin
        if (take_s) begin
          if (failure_s && (STOP_ON_ERROR != 0)) begin
            state_next_s = FAIL;
          end else if (cnt_next_s == CNT_WIDTH'(EXPECTED_BEATS)) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RUN;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      DONE:    state_next_s = DONE;
      FAIL:    state_next_s = FAIL;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    done = (state_r == DONE);
  end

  // Result counters, sticky error flag and first-failure capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count        <= 32'd0;
      mismatch_count    <= 32'd0;
      underrun_count    <= 32'd0;
      first_err_index   <= 32'd0;
      first_err_mask    <= {NUM_LANES{1'b0}};
      first_err_valid_r <= 1'b0;
      err               <= 1'b0;
    end else begin
      if (take_s) begin
        beat_count <= cnt_next_s;
      end
      if (underrun_s) begin
        underrun_count <= sat_inc(underrun_count);
      end
      if (mismatch_s) begin
        mismatch_count <= sat_inc(mismatch_count);
      end
      if (failure_s) begin
        err <= 1'b1;
        if (!first_err_valid_r) begin
          first_err_valid_r <= 1'b1;
          first_err_index   <= beat_count;
          first_err_mask    <= underrun_s ? {NUM_LANES{1'b1}} : fail_mask_s;
        end
      end
    end
  end

  // Watchdog: idle cycles in RUN, cleared on any beat, held at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_r    <= 32'd0;
      timeout <= 1'b0;
    end else begin
      if ((state_r == RUN) && !beat_s) begin
        if (wd_r != CNT_WIDTH'(TIMEOUT_CYCLES)) begin
          wd_r <= wd_r + 32'd1;
        end
      end else begin
        wd_r <= 32'd0;
      end
      if (wd_hit_s) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_comparator.sv
module tb_axis_stream_comparator;

  logic        clk;
  logic        rst;
  logic        dut_valid;
  logic        dut_ready;
  logic [63:0] dut_data;
  logic        ref_valid;
  logic [63:0] ref_data;

  logic        a_ref_ready, a_err, a_timeout, a_done;
  logic [31:0] a_beat_count, a_mismatch_count, a_underrun_count, a_first_err_index;
  logic [3:0]  a_first_err_mask;
  logic        s_ref_ready, s_err, s_timeout, s_done;
  logic [31:0] s_beat_count, s_mismatch_count, s_underrun_count, s_first_err_index;
  logic [3:0]  s_first_err_mask;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] beats;
    logic [31:0] mism;
    logic [31:0] under;
    logic [31:0] idx;
    logic [3:0]  mask;
    logic        err;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_fifo[$];
  logic [63:0] refs[16];
  int          m_state;
  logic [31:0] m_beats, m_mism, m_under, m_idx;
  logic [3:0]  m_mask;
  logic        m_err, m_seen;

  axis_stream_comparator #(
    .LANE_WIDTH(16), .NUM_LANES(4), .TOLERANCE(2), .REF_DEPTH(16),
    .EXPECTED_BEATS(8), .TIMEOUT_CYCLES(10), .STOP_ON_ERROR(0)
  ) u_dut (
    .clk(clk), .rst(rst), .dut_valid(dut_valid), .dut_ready(dut_ready),
    .dut_data(dut_data), .ref_valid(ref_valid), .ref_data(ref_data),
    .ref_ready(a_ref_ready), .beat_count(a_beat_count),
    .mismatch_count(a_mismatch_count), .underrun_count(a_underrun_count),
    .first_err_index(a_first_err_index), .first_err_mask(a_first_err_mask),
    .err(a_err), .timeout(a_timeout), .done(a_done)
  );

  axis_stream_comparator #(
    .LANE_WIDTH(16), .NUM_LANES(4), .TOLERANCE(2), .REF_DEPTH(16),
    .EXPECTED_BEATS(8), .TIMEOUT_CYCLES(10), .STOP_ON_ERROR(1)
  ) u_stop (
    .clk(clk), .rst(rst), .dut_valid(dut_valid), .dut_ready(dut_ready),
    .dut_data(dut_data), .ref_valid(ref_valid), .ref_data(ref_data),
    .ref_ready(s_ref_ready), .beat_count(s_beat_count),
    .mismatch_count(s_mismatch_count), .underrun_count(s_underrun_count),
    .first_err_index(s_first_err_index), .first_err_mask(s_first_err_mask),
    .err(s_err), .timeout(s_timeout), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkdata();
    logic [63:0] d;
    d = 64'd0;
    for (int i = 0; i < 4; i++) d[16*i +: 16] = 16'($urandom_range(32767, 0));
    return d;
  endfunction

  function automatic logic [3:0] lane_fails(input logic [63:0] d, input logic [63:0] r);
    logic [3:0] f;
    f = 4'd0;
    for (int i = 0; i < 4; i++) begin
      int a, b;
      a = int'(d[16*i +: 16]);
      b = int'(r[16*i +: 16]);
      if ((a > b ? a - b : b - a) > 2) f[i] = 1'b1;
    end
    return f;
  endfunction

  // Asynchronous reset with immediate (no clock edge) check of both instances.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_a_beats", 64'(a_beat_count), 64'd0);
    chk("rst_a_mism",  64'(a_mismatch_count), 64'd0);
    chk("rst_a_under", 64'(a_underrun_count), 64'd0);
    chk("rst_a_idx",   64'(a_first_err_index), 64'd0);
    chk("rst_a_mask",  64'(a_first_err_mask), 64'd0);
    chk("rst_a_flags", 64'({a_err, a_timeout, a_done}), 64'd0);
    chk("rst_s_beats", 64'(s_beat_count), 64'd0);
    chk("rst_s_mism",  64'(s_mismatch_count), 64'd0);
    chk("rst_s_idx",   64'(s_first_err_index), 64'd0);
    chk("rst_s_mask",  64'(s_first_err_mask), 64'd0);
    chk("rst_s_flags", 64'({s_err, s_timeout, s_done}), 64'd0);
    dut_valid = 1'b0;
    ref_valid = 1'b0;
    tick();
    rst = 1'b1;
    m_fifo.delete();
    exp_q.delete();
    m_state = 0;
    m_beats = 0; m_mism = 0; m_under = 0; m_idx = 0; m_mask = 0;
    m_err = 0; m_seen = 0;
  endtask

  task automatic push_ref(input logic [63:0] rd);
    if (m_fifo.size() < 16) m_fifo.push_back(rd);
    ref_valid = 1'b1;
    ref_data  = rd;
    tick();
    ref_valid = 1'b0;
  endtask

  // One DUT beat: model the expected result, queue it, clock, then compare.
  task automatic beat(input logic [63:0] d, input logic rv, input logic [63:0] rd);
    logic [63:0] r;
    logic        have_ref, full_b, bypass;
    logic [3:0]  fm;
    exp_t        e;
    full_b = (m_fifo.size() >= 16);
    bypass = 1'b0;
    if (m_state < 2) begin
      have_ref = 1'b1;
      r = 64'd0;
      if (m_fifo.size() > 0) r = m_fifo.pop_front();
      else if (rv) begin r = rd; bypass = 1'b1; end
      else have_ref = 1'b0;
      fm = have_ref ? lane_fails(d, r) : 4'hF;
      if (!have_ref) m_under++;
      else if (fm != 4'd0) m_mism++;
      if (fm != 4'd0) begin
        m_err = 1'b1;
        if (!m_seen) begin m_seen = 1'b1; m_idx = m_beats; m_mask = fm; end
      end
      m_beats++;
      m_state = (m_beats == 32'd8) ? 2 : 1;
    end
    if (rv && !full_b && !bypass) m_fifo.push_back(rd);
    e.beats = m_beats; e.mism = m_mism; e.under = m_under; e.idx = m_idx;
    e.mask = m_mask; e.err = m_err; e.done = (m_state == 2);
    exp_q.push_back(e);
    dut_valid = 1'b1;
    dut_data  = d;
    ref_valid = rv;
    ref_data  = rd;
    tick();
    dut_valid = 1'b0;
    ref_valid = 1'b0;
    e = exp_q.pop_front();
    chk("sb_beats", 64'(a_beat_count), 64'(e.beats));
    chk("sb_mism",  64'(a_mismatch_count), 64'(e.mism));
    chk("sb_under", 64'(a_underrun_count), 64'(e.under));
    chk("sb_idx",   64'(a_first_err_index), 64'(e.idx));
    chk("sb_mask",  64'(a_first_err_mask), 64'(e.mask));
    chk("sb_err",   64'(a_err), 64'(e.err));
    chk("sb_done",  64'(a_done), 64'(e.done));
  endtask

  initial begin
    logic [63:0] d;
    rst = 1'b0; dut_valid = 1'b0; dut_ready = 1'b1; dut_data = 64'd0;
    ref_valid = 1'b0; ref_data = 64'd0;
    #1;
    do_reset();
    chk("ready_after_reset", 64'(a_ref_ready), 64'd1);

    // Clean run: preload 8, stream 8 identical beats, then one ignored beat.
    for (int k = 0; k < 8; k++) begin refs[k] = mkdata(); push_ref(refs[k]); end
    for (int k = 0; k < 8; k++) beat(refs[k], 1'b0, 64'd0);
    chk("clean_done", 64'(a_done), 64'd1);
    chk("clean_beats", 64'(a_beat_count), 64'd8);
    chk("clean_err", 64'(a_err), 64'd0);
    beat(mkdata(), 1'b0, 64'd0);
    chk("done_ignores_beat", 64'(a_beat_count), 64'd8);

    // Tolerance: +2 on lane1 of beat 3 passes, +3 on lane2 of beat 5 fails.
    do_reset();
    for (int k = 0; k < 8; k++) begin refs[k] = mkdata(); push_ref(refs[k]); end
    for (int k = 0; k < 8; k++) begin
      d = refs[k];
      if (k == 3) d[31:16] = d[31:16] + 16'd2;
      if (k == 5) d[47:32] = d[47:32] + 16'd3;
      beat(d, 1'b0, 64'd0);
    end
    chk("tol_mism", 64'(a_mismatch_count), 64'd1);
    chk("tol_idx", 64'(a_first_err_index), 64'd5);
    chk("tol_mask", 64'(a_first_err_mask), 64'h4);

    // Underrun, then bypass, then underrun again (bypass stored nothing).
    do_reset();
    beat(mkdata(), 1'b0, 64'd0);
    chk("under_cnt", 64'(a_underrun_count), 64'd1);
    chk("under_mask", 64'(a_first_err_mask), 64'hF);
    d = mkdata();
    beat(d, 1'b1, d);
    chk("bypass_no_under", 64'(a_underrun_count), 64'd1);
    beat(mkdata(), 1'b0, 64'd0);
    chk("bypass_not_stored", 64'(a_underrun_count), 64'd2);
    d = mkdata();
    refs[0] = d;
    refs[0][15:0] = d[15:0] ^ 16'h0100;
    beat(d, 1'b1, refs[0]);
    chk("bypass_mismatch", 64'(a_mismatch_count), 64'd1);

    // Full FIFO: ref_ready drops; pop with ref_valid frees one slot.
    do_reset();
    for (int k = 0; k < 16; k++) begin refs[k] = mkdata(); push_ref(refs[k]); end
    chk("full_ready", 64'(a_ref_ready), 64'd0);
    push_ref(mkdata());
    beat(refs[0], 1'b1, mkdata());
    chk("pop_frees_ready", 64'(a_ref_ready), 64'd1);
    push_ref(mkdata());
    chk("refull_ready", 64'(a_ref_ready), 64'd0);
    beat(refs[1], 1'b0, 64'd0);
    beat(refs[2], 1'b0, 64'd0);

    // Stop on error: mismatch on beat index 2 freezes the stopping instance.
    do_reset();
    for (int k = 0; k < 8; k++) begin refs[k] = mkdata(); push_ref(refs[k]); end
    for (int k = 0; k < 8; k++) begin
      d = refs[k];
      if (k == 2) d[15:0] = d[15:0] + 16'd5;
      beat(d, 1'b0, 64'd0);
    end
    chk("stop_beats", 64'(s_beat_count), 64'd3);
    chk("stop_mism", 64'(s_mismatch_count), 64'd1);
    chk("stop_idx", 64'(s_first_err_index), 64'd2);
    chk("stop_mask", 64'(s_first_err_mask), 64'h1);
    chk("stop_flags", 64'({s_err, s_done}), 64'h2);
    dut_valid = 1'b1;
    dut_data  = mkdata();
    tick();
    chk("stop_frozen", 64'(s_beat_count), 64'd3);
    do_reset();

    // Watchdog fires eleven cycles after a lone beat.
    for (int k = 0; k < 2; k++) begin refs[k] = mkdata(); push_ref(refs[k]); end
    beat(refs[0], 1'b0, 64'd0);
    repeat (9) tick();
    chk("wd_early", 64'(a_timeout), 64'd0);
    tick();
    chk("wd_fire", 64'(a_timeout), 64'd1);
    chk("wd_fire_stop", 64'(s_timeout), 64'd1);
    chk("wd_state_kept", 64'(a_done), 64'd0);

    // A beat on cycle 9 restarts the count.
    do_reset();
    for (int k = 0; k < 2; k++) begin refs[k] = mkdata(); push_ref(refs[k]); end
    beat(refs[0], 1'b0, 64'd0);
    repeat (8) tick();
    beat(refs[1], 1'b0, 64'd0);
    tick();
    chk("wd_prevented", 64'(a_timeout), 64'd0);
    repeat (8) tick();
    chk("wd_restart_early", 64'(a_timeout), 64'd0);
    tick();
    chk("wd_restart_fire", 64'(a_timeout), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_stream_comparator.md
# axis_stream_comparator

Passive, parametrised AXIS stream checker for simulation benches. It observes a DUT handshake without driving it, and buffers an independent reference stream in an internal FIFO. Each observed beat is compared lane-by-lane against the reference with a configurable tolerance. Results are exposed as registered counters, sticky flags and first-error capture, so benches can assert on them instead of parsing logs.

## Interface
- LANE_WIDTH, 16: bits per lane.
- NUM_LANES, 4: lanes per beat; data width is NUM_LANES*LANE_WIDTH.
- TOLERANCE, 0: maximum absolute unsigned difference per lane still counted as a match.
- REF_DEPTH, 16: reference FIFO depth; power of two, at least 2.
- EXPECTED_BEATS, 1024: beat count at which the run is complete.
- TIMEOUT_CYCLES, 4096: idle cycles in RUN before timeout; 0 disables the watchdog.
- STOP_ON_ERROR, 0: 1 freezes comparison at the first failure.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-low.
- dut_valid  in  1  observed valid.
- dut_ready  in  1  observed ready.
- dut_data  in  NUM_LANES*LANE_WIDTH  observed data.
- ref_valid  in  1  reference stream valid.
- ref_data  in  NUM_LANES*LANE_WIDTH  reference stream data.
- ref_ready  out  1  reference accept.
- beat_count  out  32  number of compared beats.
- mismatch_count  out  32  number of beats with at least one failing lane.
- underrun_count  out  32  number of DUT beats that had no reference available.
- first_err_index  out  32  beat_count value at the first failure.
- first_err_mask  out  NUM_LANES  failing lanes of the first failure.
- err  out  1  sticky, set by any mismatch or underrun.
- timeout  out  1  sticky watchdog flag.
- done  out  1  level output, high in the DONE state.

## Operation
- A DUT beat is a cycle where dut_valid & dut_ready is 1.
- ref_ready is !fifo_full. A reference push happens on ref_valid & ref_ready.
- On each DUT beat:
  - FIFO non-empty: pop the head and compare against it.
  - FIFO empty with ref_valid=1: bypass, compare against ref_data directly; nothing is stored.
  - FIFO empty with ref_valid=0: underrun. underrun_count+1, err=1, no comparison is made, and beat_count still increments.
- Lane i passes when |dut lane − ref lane| ≤ TOLERANCE, computed unsigned on LANE_WIDTH+1 bits. Any X/Z bit in a dut lane fails that lane (=== check).
- A beat with any failing lane increments mismatch_count and sets err.
- first_err_index and first_err_mask load only on the first failure, underrun included; an underrun loads mask all-ones.
- State machine:
  - IDLE → RUN on the first DUT beat.
  - RUN → DONE when beat_count reaches EXPECTED_BEATS.
  - RUN → FAIL on a failure when STOP_ON_ERROR=1.
  - DONE and FAIL are terminal until reset.
  - In DONE and FAIL, DUT beats are ignored: no counts change and no pops occur. The FIFO keeps accepting reference data until full.
- Watchdog counts cycles in RUN without a DUT beat and clears on every beat. At TIMEOUT_CYCLES it sets timeout; the state is unchanged.
- Counters saturate at 2^32−1.

## Timing
- Reset (rst=0, asynchronous) puts the block in IDLE, empties the FIFO, and clears all counters, flags, first_err_* and done to 0. ref_ready is 1 whenever reset is deasserted and the FIFO is not full.
- Compare latency: all result outputs update on the clock edge ending the beat cycle, i.e. they are visible the cycle after the beat.
- Push and pop in the same cycle are legal when the FIFO is non-empty; occupancy is unchanged.
- When full, ref_ready=0 even if a pop happens that cycle; there is no combinational path from dut_* to ref_ready.
- FIFO pointers are log2(REF_DEPTH)+1 bits and wrap naturally; full = MSBs differ and the remaining bits are equal.
- done asserts the cycle after the EXPECTED_BEATS-th beat.
- Asserting reset mid-run abandons the run: buffered reference data is discarded and no flags persist.

## Structure
- Package axis_checker_pkg holds the state enum (IDLE, RUN, DONE, FAIL), the counter width constant (32), and a function lane_match(dut, ref, tol).
- Sub-module checker_ref_fifo: a synchronous FIFO with an asynchronous active-low reset, parameters WIDTH and DEPTH, and ports push, pop, din, dout, full, empty.
- The top level contains the bypass mux, lane comparators, FSM, counters and watchdog.

## Test plan
- Preload 8 reference beats, then stream 8 identical DUT beats with ready always high → beat_count=8, mismatch_count=0, err=0; with EXPECTED_BEATS=8, done=1.
- TOLERANCE=2, lane 1 of beat 3 differs by 2, lane 2 of beat 5 differs by 3 → mismatch_count=1, first_err_index=5, first_err_mask=4'b0100.
- Reference held off (ref_valid=0) during the first DUT beat → underrun_count=1, first_err_mask=4'b1111; the next beat, with ref_valid=1 and the FIFO empty, compares via bypass with no additional underrun.
- Fill the FIFO to REF_DEPTH=16 → ref_ready=0; then a simultaneous DUT beat and ref_valid → occupancy drops to 15 and ref_ready returns to 1 the next cycle.
- STOP_ON_ERROR=1, mismatch on beat 2 followed by 5 further beats → beat_count=3 and FAIL persists; then assert rst=0 mid-stream → all outputs 0 asynchronously.
- TIMEOUT_CYCLES=10 with the DUT idle after 1 beat → timeout=1 eleven cycles after that beat; a beat on cycle 9 prevents it.
